// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU background pixel path.
package ppu_pkg;
  localparam int PAL_ADDR_W    = 5;
  localparam int PIX_W         = 4;
  localparam int MASK_COLS_DEF = 8;
  localparam int PLANE_W       = 16;

  typedef struct packed {
    logic [1:0] attr;
    logic [1:0] pat;
  } bg_pix_t;

  // Pattern value 0 is transparent and always maps to the universal backdrop.
  function automatic logic [PAL_ADDR_W-1:0] bg_pal_addr(bg_pix_t pix);
    return (pix.pat == 2'b00) ? '0 : {1'b0, pix};
  endfunction
endpackage

// File: rtl/bg_pixel_shifter_if.sv
// Tile-fetch, scroll/mask controls and palette-address outputs of the background pixel stage.
interface bg_pixel_shifter_if;
  import ppu_pkg::*;

  logic                  line_start;
  logic                  shift_en;
  logic                  load;
  logic [7:0]            pat_lo;
  logic [7:0]            pat_hi;
  logic [1:0]            attr;
  logic [2:0]            fine_x;
  logic                  show_bg;
  logic                  show_bg_left;
  logic                  pix_valid;
  logic [PIX_W-1:0]      bg_pix;
  logic [PAL_ADDR_W-1:0] pal_addr;

  modport master (
    output line_start, shift_en, load, pat_lo, pat_hi, attr,
           fine_x, show_bg, show_bg_left, pix_valid,
    input  bg_pix, pal_addr
  );

  modport slave (
    input  line_start, shift_en, load, pat_lo, pat_hi, attr,
           fine_x, show_bg, show_bg_left, pix_valid,
    output bg_pix, pal_addr
  );
endinterface

// File: rtl/bg_plane_shift.sv
// One 16-bit background plane: shifts left, reloads its low byte with the next tile, taps one bit.
module bg_plane_shift
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_en,
  input  logic       load,
  input  logic [7:0] din,
  input  logic [3:0] sel,
  output logic       tap
);

  logic [PLANE_W-1:0] sh;

  // A load happens on the same edge as a shift, so the upper byte takes the shifted bits 14:7.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh <= '0;
    end else if (shift_en) begin
      if (load) sh <= {sh[PLANE_W-2:7], din};
      else      sh <= {sh[PLANE_W-2:0], 1'b0};
    end
  end

  assign tap = sh[sel];

endmodule

// File: rtl/bg_pixel_shifter.sv
// Background pixel stage: tile shift planes, fine-X select, enable/left-column mask, palette address.
module bg_pixel_shifter
  import ppu_pkg::*;
#(
  parameter int MASK_COLS = MASK_COLS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  bg_pixel_shifter_if.slave bus
);

  logic [3:0]            sel;
  logic                  tap_pat_lo;
  logic                  tap_pat_hi;
  logic                  tap_at_lo;
  logic                  tap_at_hi;
  bg_pix_t               raw;
  bg_pix_t               pix_next;
  logic                  masked;
  logic [7:0]            col;
  bg_pix_t               bg_pix_q;
  logic [PAL_ADDR_W-1:0] pal_addr_q;

  assign sel = 4'd15 - {1'b0, bus.fine_x};

  bg_plane_shift u_pat_lo (
    .clk      (clk),
    .rst      (rst),
    .shift_en (bus.shift_en),
    .load     (bus.load),
    .din      (bus.pat_lo),
    .sel      (sel),
    .tap      (tap_pat_lo)
  );

  bg_plane_shift u_pat_hi (
    .clk      (clk),
    .rst      (rst),
    .shift_en (bus.shift_en),
    .load     (bus.load),
    .din      (bus.pat_hi),
    .sel      (sel),
    .tap      (tap_pat_hi)
  );

  bg_plane_shift u_at_lo (
    .clk      (clk),
    .rst      (rst),
    .shift_en (bus.shift_en),
    .load     (bus.load),
    .din      ({8{bus.attr[0]}}),
    .sel      (sel),
    .tap      (tap_at_lo)
  );

  bg_plane_shift u_at_hi (
    .clk      (clk),
    .rst      (rst),
    .shift_en (bus.shift_en),
    .load     (bus.load),
    .din      ({8{bus.attr[1]}}),
    .sel      (sel),
    .tap      (tap_at_hi)
  );

  assign raw = {tap_at_hi, tap_at_lo, tap_pat_hi, tap_pat_lo};

  // Mask uses the column of the pixel being emitted, i.e. col before this edge's increment.
  assign masked = !bus.pix_valid || !bus.show_bg ||
                  (!bus.show_bg_left && (int'(col) < MASK_COLS));

  assign pix_next = masked ? bg_pix_t'('0) : raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      bg_pix_q   <= '0;
      pal_addr_q <= '0;
    end else begin
      if (bus.line_start)                    col <= '0;
      else if (bus.pix_valid && col != 8'hFF) col <= col + 8'd1;
      bg_pix_q   <= pix_next;
      pal_addr_q <= bg_pal_addr(pix_next);
    end
  end

  assign bus.bg_pix   = bg_pix_q;
  assign bus.pal_addr = pal_addr_q;

endmodule

// File: tb/tb_bg_pixel_shifter.sv
// Directed bench for bg_pixel_shifter: reset, tile loads, fine scroll, masking, column counter.
module tb_bg_pixel_shifter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bg_pixel_shifter_if bif ();

  bg_pixel_shifter #(.MASK_COLS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bif.load === 1'b1 && bif.shift_en !== 1'b1) begin
      errors++;
      $display("FAIL load_without_shift_en at %0t: load=%b shift_en=%b", $time, bif.load, bif.shift_en);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bif.line_start   = 1'b0;
    bif.shift_en     = 1'b0;
    bif.load         = 1'b0;
    bif.pat_lo       = 8'h00;
    bif.pat_hi       = 8'h00;
    bif.attr         = 2'b00;
    bif.fine_x       = 3'd0;
    bif.show_bg      = 1'b0;
    bif.show_bg_left = 1'b0;
    bif.pix_valid    = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // Tile under test ends up in bits 15:8, an all-zero tile in 7:0; col cleared on the final cycle.
  task automatic prime_tile(input logic [7:0] lo, input logic [7:0] hi, input logic [1:0] at);
    bif.pix_valid = 1'b0;
    bif.shift_en  = 1'b1;
    bif.load      = 1'b1;
    bif.pat_lo    = lo;
    bif.pat_hi    = hi;
    bif.attr      = at;
    cyc();
    bif.load = 1'b0;
    repeat (7) cyc();
    bif.load       = 1'b1;
    bif.pat_lo     = 8'h00;
    bif.pat_hi     = 8'h00;
    bif.attr       = 2'b00;
    bif.line_start = 1'b1;
    cyc();
    bif.load       = 1'b0;
    bif.line_start = 1'b0;
    bif.pix_valid  = 1'b1;
  endtask

  // All planes filled with ones (pat 11, attr 11); col cleared on the final cycle.
  task automatic prime_ones();
    bif.pix_valid = 1'b0;
    bif.shift_en  = 1'b1;
    bif.load      = 1'b1;
    bif.pat_lo    = 8'hFF;
    bif.pat_hi    = 8'hFF;
    bif.attr      = 2'b11;
    repeat (9) cyc();
    bif.line_start = 1'b1;
    cyc();
    bif.line_start = 1'b0;
    bif.pix_valid  = 1'b1;
  endtask

  task automatic test_reset();
    logic sh;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rst = 1'b0;
      sh               = 1'($urandom_range(0, 1));
      bif.shift_en     = sh;
      bif.load         = sh & 1'($urandom_range(0, 1));
      bif.pat_lo       = 8'($urandom);
      bif.pat_hi       = 8'($urandom);
      bif.attr         = 2'($urandom);
      bif.fine_x       = 3'($urandom);
      bif.show_bg      = 1'b1;
      bif.show_bg_left = 1'b1;
      bif.pix_valid    = 1'b1;
      bif.line_start   = 1'($urandom_range(0, 1));
      cyc();
      checks++;
      if (bif.bg_pix !== 4'h0 || bif.pal_addr !== 5'h00) begin
        errors++;
        $display("FAIL reset cycle %0d: bg_pix=%h pal_addr=%h want 0/00", i, bif.bg_pix, bif.pal_addr);
      end
    end
  endtask

  task automatic test_two_loads();
    logic [3:0] exp_pix [0:8];
    logic [4:0] exp_pal [0:8];
    exp_pix = '{4'hB, 4'h9, 4'hB, 4'h9, 4'hA, 4'h8, 4'hA, 4'h8, 4'h0};
    exp_pal = '{5'h0B, 5'h09, 5'h0B, 5'h09, 5'h0A, 5'h00, 5'h0A, 5'h00, 5'h00};
    do_reset();
    bif.show_bg      = 1'b1;
    bif.show_bg_left = 1'b1;
    bif.fine_x       = 3'd0;
    prime_tile(8'hF0, 8'hAA, 2'b10);
    for (int k = 0; k < 9; k++) begin
      cyc();
      checks++;
      if (bif.bg_pix !== exp_pix[k] || bif.pal_addr !== exp_pal[k]) begin
        errors++;
        $display("FAIL two_loads px%0d: bg_pix=%h pal_addr=%h want %h/%h",
                 k, bif.bg_pix, bif.pal_addr, exp_pix[k], exp_pal[k]);
      end
    end
  endtask

  task automatic test_fine_scroll();
    logic [3:0] exp_pix [0:5];
    logic [4:0] exp_pal [0:5];
    exp_pix = '{4'h9, 4'hA, 4'h8, 4'hA, 4'h8, 4'h0};
    exp_pal = '{5'h09, 5'h0A, 5'h00, 5'h0A, 5'h00, 5'h00};
    do_reset();
    bif.show_bg      = 1'b1;
    bif.show_bg_left = 1'b1;
    bif.fine_x       = 3'd3;
    prime_tile(8'hF0, 8'hAA, 2'b10);
    for (int k = 0; k < 6; k++) begin
      cyc();
      checks++;
      if (bif.bg_pix !== exp_pix[k] || bif.pal_addr !== exp_pal[k]) begin
        errors++;
        $display("FAIL fine_scroll px%0d: bg_pix=%h pal_addr=%h want %h/%h",
                 k, bif.bg_pix, bif.pal_addr, exp_pix[k], exp_pal[k]);
      end
    end
  endtask

  task automatic test_fine_hold();
    logic [2:0] fx      [0:3];
    logic [3:0] exp_pix [0:3];
    fx      = '{3'd0, 3'd1, 3'd4, 3'd7};
    exp_pix = '{4'hB, 4'h9, 4'hA, 4'h8};
    do_reset();
    bif.show_bg      = 1'b1;
    bif.show_bg_left = 1'b1;
    bif.fine_x       = 3'd0;
    prime_tile(8'hF0, 8'hAA, 2'b10);
    bif.shift_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bif.fine_x = fx[k];
      cyc();
      checks++;
      if (bif.bg_pix !== exp_pix[k]) begin
        errors++;
        $display("FAIL fine_hold fine_x=%0d: bg_pix=%h want %h", fx[k], bif.bg_pix, exp_pix[k]);
      end
    end
  endtask

  task automatic test_left_mask();
    do_reset();
    bif.show_bg      = 1'b1;
    bif.show_bg_left = 1'b0;
    prime_ones();
    for (int k = 0; k < 12; k++) begin
      cyc();
      checks++;
      if (k < 8) begin
        if (bif.bg_pix !== 4'h0 || bif.pal_addr !== 5'h00) begin
          errors++;
          $display("FAIL left_mask col%0d: bg_pix=%h pal_addr=%h want 0/00", k, bif.bg_pix, bif.pal_addr);
        end
      end else begin
        if (bif.bg_pix !== 4'hF || bif.pal_addr !== 5'h0F) begin
          errors++;
          $display("FAIL left_mask col%0d: bg_pix=%h pal_addr=%h want F/0F", k, bif.bg_pix, bif.pal_addr);
        end
      end
    end
  endtask

  task automatic test_show_bg_off();
    do_reset();
    bif.show_bg      = 1'b0;
    bif.show_bg_left = 1'b1;
    prime_ones();
    for (int k = 0; k < 259; k++) begin
      cyc();
      checks++;
      if (bif.bg_pix !== 4'h0 || bif.pal_addr !== 5'h00) begin
        errors++;
        $display("FAIL show_bg_off col%0d: bg_pix=%h pal_addr=%h want 0/00", k, bif.bg_pix, bif.pal_addr);
      end
    end
    // col is saturated at 255, so left masking must not apply
    bif.show_bg      = 1'b1;
    bif.show_bg_left = 1'b0;
    cyc();
    checks++;
    if (bif.bg_pix !== 4'hF || bif.pal_addr !== 5'h0F) begin
      errors++;
      $display("FAIL col_saturate: bg_pix=%h pal_addr=%h want F/0F", bif.bg_pix, bif.pal_addr);
    end
    bif.pix_valid  = 1'b0;
    bif.line_start = 1'b1;
    cyc();
    bif.line_start = 1'b0;
    bif.pix_valid  = 1'b1;
    cyc();
    checks++;
    if (bif.bg_pix !== 4'h0 || bif.pal_addr !== 5'h00) begin
      errors++;
      $display("FAIL col_restart: bg_pix=%h pal_addr=%h want 0/00", bif.bg_pix, bif.pal_addr);
    end
  endtask

  task automatic test_line_start_coincident();
    do_reset();
    bif.show_bg      = 1'b1;
    bif.show_bg_left = 1'b0;
    prime_ones();
    repeat (20) cyc();
    bif.line_start = 1'b1;
    cyc();
    bif.line_start = 1'b0;
    checks++;
    if (bif.bg_pix !== 4'hF) begin
      errors++;
      $display("FAIL coincident_col20: bg_pix=%h want F", bif.bg_pix);
    end
    for (int k = 0; k < 9; k++) begin
      cyc();
      if (k == 0 || k == 7) begin
        checks++;
        if (bif.bg_pix !== 4'h0 || bif.pal_addr !== 5'h00) begin
          errors++;
          $display("FAIL coincident col%0d: bg_pix=%h pal_addr=%h want 0/00", k, bif.bg_pix, bif.pal_addr);
        end
      end else if (k == 8) begin
        checks++;
        if (bif.bg_pix !== 4'hF || bif.pal_addr !== 5'h0F) begin
          errors++;
          $display("FAIL coincident col8: bg_pix=%h pal_addr=%h want F/0F", bif.bg_pix, bif.pal_addr);
        end
      end
    end
  endtask

  initial begin
    set_idle();
    rst = 1'b0;
    test_reset();
    test_two_loads();
    test_fine_scroll();
    test_fine_hold();
    test_left_mask();
    test_show_bg_off();
    test_line_start_coincident();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
